// File: rtl/sram_uart_dumper.sv
// sram_uart_dumper: streams a block of 16-bit SRAM words out of an 8N1 UART,
// high byte first. The next word is read while the low byte is shifting out,
// so consecutive frames of one dump follow each other with no idle gap.
module sram_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 18
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Word_count,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic              SRAM_we_n,
  output logic [15:0]       SRAM_write_data,
  input  logic [15:0]       SRAM_read_data,
  output logic              UART_TX_O,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT1   = 3'd2;
  localparam logic [2:0] S_WAIT2   = 3'd3;
  localparam logic [2:0] S_TX_HIGH = 3'd4;
  localparam logic [2:0] S_TX_LOW  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [15:0]       word_buf;
  logic [15:0]       next_buf;
  logic              next_valid;
  logic [1:0]        pf_pipe;     // prefetch read in flight: [0] issued, [1] data valid now
  logic [CNT_W-1:0]  clk_cnt;
  logic [3:0]        bit_idx;     // 0 start, 1..8 data LSB first, 9 stop
  logic [7:0]        tx_byte;
  logic              frame_bit;

  // Block never writes the SRAM.
  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = 16'h0000;

  // Select the serial level for the current bit slot of the active byte.
  always_comb begin
    tx_byte   = 8'h00;
    frame_bit = 1'b1;
    if (state == S_TX_HIGH) begin
      tx_byte = word_buf[15:8];
    end else begin
      tx_byte = word_buf[7:0];
    end
    if (bit_idx == 4'd0) begin
      frame_bit = 1'b0;
    end else if (bit_idx == 4'd9) begin
      frame_bit = 1'b1;
    end else begin
      // bit_idx 1..8 maps to data bit 0..7 (8 wraps to 7 in three bits).
      frame_bit = tx_byte[bit_idx[2:0] - 3'd1];
    end
  end

  // Dump sequencer: SRAM reads, prefetch pipeline, and bit timing.
  // The UART output is registered, so each TX edge drives the bit slot
  // named by the counters; the output therefore trails the counters by one cycle.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      addr         <= '0;
      remaining    <= '0;
      word_buf     <= 16'h0000;
      next_buf     <= 16'h0000;
      next_valid   <= 1'b0;
      pf_pipe      <= 2'b00;
      clk_cnt      <= '0;
      bit_idx      <= 4'd0;
      SRAM_address <= '0;
      UART_TX_O    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      Done    <= 1'b0;
      pf_pipe <= {pf_pipe[0], 1'b0};
      if (pf_pipe[1]) begin
        next_buf   <= SRAM_read_data;
        next_valid <= 1'b1;
        remaining  <= remaining - ADDR_W'(1);
      end
      case (state)
        S_IDLE: begin
          UART_TX_O <= 1'b1;
          if (Start) begin
            addr      <= Base_address;
            remaining <= Word_count;
            if (Word_count == '0) begin
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
              Busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          SRAM_address <= addr;
          addr         <= addr + ADDR_W'(1);
          state        <= S_WAIT1;
        end
        S_WAIT1: begin
          state <= S_WAIT2;
        end
        S_WAIT2: begin
          word_buf  <= SRAM_read_data;
          remaining <= remaining - ADDR_W'(1);
          clk_cnt   <= '0;
          bit_idx   <= 4'd0;
          state     <= S_TX_HIGH;
        end
        S_TX_HIGH, S_TX_LOW: begin
          UART_TX_O <= frame_bit;
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= 4'd0;
              if (state == S_TX_HIGH) begin
                state <= S_TX_LOW;
                if (remaining != '0) begin
                  SRAM_address <= addr;
                  addr         <= addr + ADDR_W'(1);
                  pf_pipe      <= 2'b01;
                end
              end else if (next_valid) begin
                word_buf   <= next_buf;
                next_valid <= 1'b0;
                state      <= S_TX_HIGH;
              end else begin
                state <= S_DONE;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          UART_TX_O <= 1'b1;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_uart_dumper.md
Name: sram_uart_dumper

Overview:
Reads a contiguous block of 16-bit words from external SRAM through the SRAM controller and transmits it over UART as 8N1 serial bytes, high byte first and then low byte. This is the transmit-side counterpart of the UART-to-SRAM receive path. The decompressor top level uses it after decoding to stream the result image (for example, the RGB region at the VGA base address) back to the host.

Parameters:
CLKS_PER_BIT, 434, Clock_50 cycles per UART bit (115200 baud at 50 MHz); minimum 2.
ADDR_W, 18, SRAM word-address width.

Ports:
Clock_50  in  1  system clock, 50 MHz
Resetn  in  1  asynchronous, active-low reset
Start  in  1  pulse; begin a dump (sampled only in S_IDLE)
Base_address  in  ADDR_W  first word address, latched on Start
Word_count  in  ADDR_W  number of words to send, latched on Start
SRAM_address  out  ADDR_W  word address to the SRAM controller
SRAM_we_n  out  1  always 1 (read-only block)
SRAM_write_data  out  16  always 16'h0000
SRAM_read_data  in  16  controller read data, valid 2 cycles after the address is presented
UART_TX_O  out  1  serial output, idle high
Busy  out  1  high from the cycle after Start until Done
Done  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values (asynchronous, take effect immediately): UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, SRAM_we_n=1, SRAM_write_data=0. All counters clear and the FSM goes to S_IDLE.
- States: S_IDLE, S_ISSUE, S_WAIT1, S_WAIT2, S_TX_HIGH, S_TX_LOW, S_DONE.
- S_IDLE:
  - Start=1 latches Base_address into addr and Word_count into remaining.
  - If Word_count=0, go to S_DONE with no SRAM access.
  - Otherwise go to S_ISSUE.
- S_ISSUE: SRAM_address=addr; addr increments mod 2^ADDR_W.
- S_WAIT1, then S_WAIT2: on the S_WAIT2 edge, SRAM_read_data is captured into word_buf and remaining decrements.
- Latency: Start at edge k gives SRAM_address=Base in cycle k+1, capture at edge k+3, and the start bit (UART_TX_O=0) from cycle k+4.
- Frame format (8N1):
  - 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles; one frame is 10*CLKS_PER_BIT cycles.
- S_TX_HIGH sends word_buf[15:8]. S_TX_LOW sends word_buf[7:0].
- Prefetch:
  - On entry to S_TX_LOW, if remaining>0, the next read is issued (SRAM_address=addr, addr++).
  - The read data goes to next_buf 2 cycles later; remaining decrements.
  - At the end of the low frame's stop bit, next_buf moves to word_buf and the next start bit begins in the following cycle.
  - Result: no idle gap between any two frames of one dump.
- When the low frame's stop bit ends with remaining=0: go to S_DONE.
- S_DONE: Done=1 for exactly one cycle, Busy=0 in the same cycle, then S_IDLE.
- Total dump time for N>0 words: 4 + 20*N*CLKS_PER_BIT cycles from the Start edge to the Done pulse.
- Start while Busy=1 is ignored, and Base_address/Word_count changes during a dump have no effect.
- Address wrap: Base_address+N beyond 2^ADDR_W-1 wraps to 0, with no error.
- Outside S_ISSUE and the prefetch issue cycle, SRAM_address holds its last value and SRAM_we_n stays 1.
- Reset mid-frame: UART_TX_O goes to 1 at once, the partial byte is discarded, and no Done pulse is produced.

Test Plan:
1. CLKS_PER_BIT=4, Base=0x00010, Count=1, SRAM[0x10]=16'hA53C, Start at edge k:
   - SRAM_address=0x10 in cycle k+1; TX low from k+4.
   - Decoded bytes are 0xA5 then 0x3C (bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0).
   - Done at k+4+80.
2. Count=3 at 0x20..0x22 = 0x0102, 0x0304, 0x0506:
   - Six bytes 01 02 03 04 05 06, with no idle-high cycle between frames.
   - Exactly 3 SRAM addresses are issued; Done after 4+240 cycles.
3. Count=0 -> Done pulses at edge k+1, no SRAM_address change, UART_TX_O stays 1, Busy never rises.
4. Base=0x3FFFF, Count=2 -> addresses 0x3FFFF then 0x00000; 4 bytes are sent.
5. Start re-pulsed at mid-dump, and Base/Count changed -> the byte stream and Done timing are identical to the undisturbed run.
6. Resetn low during the 3rd data bit of frame 1 -> UART_TX_O=1 immediately, no Done. After release, a new Start runs scenario 1 correctly.
